// File: rtl/cpu_loader_pkg.sv
// Shared constants, FSM encoding and helpers for the CPU loader.
package cpu_loader_pkg;
  localparam int DATA_W = 64;
  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam int CNT_W  = 11;
  localparam int RUN_W  = 32;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD_I    = 3'd1;
  localparam logic [2:0] S_LOAD_D    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_DUMP_RD   = 3'd4;
  localparam logic [2:0] S_DUMP_WAIT = 3'd5;
  localparam logic [2:0] S_DUMP_OUT  = 3'd6;

  typedef struct packed {
    logic [CNT_W-1:0] inst;
    logic [CNT_W-1:0] data;
    logic [CNT_W-1:0] dump;
    logic [RUN_W-1:0] run;
  } lens_t;

  // A length beyond the memory depth is limited to the depth.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len,
                                                 input int unsigned depth);
    if (32'(len) > depth) return CNT_W'(depth);
    return len;
  endfunction

  // Phase that follows cur, skipping every phase whose length is zero.
  function automatic logic [2:0] after_phase(input logic [2:0] cur, input lens_t l);
    logic [2:0] s;
    s = S_IDLE;
    if (l.dump != '0) s = S_DUMP_RD;
    if (cur != S_RUN && l.run != '0) s = S_RUN;
    if (cur == S_LOAD_I && l.data != '0) s = S_LOAD_D;
    return s;
  endfunction
endpackage

// File: rtl/cpu_loader_if.sv
// Load and dump streams between a host and the CPU loader.
interface cpu_loader_if;
  import cpu_loader_pkg::*;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data);
  modport slave  (input  in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data);
endinterface

// File: rtl/loader_counter.sv
// Loadable up-counter with a terminal-count flag at a programmable last value.
module loader_counter #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] count,
  output logic         tc
);
  // Clear wins over increment so every phase starts from index 0.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)     count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count + W'(1);
  end

  assign tc = (count == last);
endmodule

// File: rtl/cpu_loader.sv
// Loads instruction/data memories from a stream, runs the CPU for a fixed
// number of cycles, then streams a region of data memory back out.
module cpu_loader import cpu_loader_pkg::*; #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               start,
  input  logic [9:0]         n_inst,
  input  logic [10:0]        n_data,
  input  logic [10:0]        n_dump,
  input  logic [RUN_W-1:0]   run_cycles,
  cpu_loader_if.slave        strm,
  output logic               busy,
  output logic               done,
  output logic               cpu_enable,
  output logic               cpu_arst_n,
  output logic [ADDR_W-1:0]  addr_ext,
  output logic               wen_ext,
  output logic               ren_ext,
  output logic [INST_W-1:0]  wdata_ext,
  output logic [ADDR_W-1:0]  addr_ext_2,
  output logic               wen_ext_2,
  output logic               ren_ext_2,
  output logic [DATA_W-1:0]  wdata_ext_2,
  input  logic [DATA_W-1:0]  rdata_ext_2
);
  logic [2:0]        state, state_nx;
  lens_t             len;
  logic [CNT_W-1:0]  beat, beat_last, dump_idx, dump_last;
  logic [RUN_W-1:0]  cyc;
  logic              beat_tc, cyc_tc, dump_tc;
  logic              in_rdy, accept, rd_go;
  logic [ADDR_W-1:0] waddr2;
  logic [DATA_W-1:0] out_data_r;

  assign busy      = (state != S_IDLE);
  assign in_rdy    = (state == S_LOAD_I && len.inst != '0) || (state == S_LOAD_D);
  assign accept    = strm.in_valid && in_rdy;
  assign beat_last = ((state == S_LOAD_D) ? len.data : len.inst) - CNT_W'(1);
  assign dump_last = len.dump - CNT_W'(1);
  // A read is held off while the final data-memory write still occupies the port.
  assign rd_go     = (state == S_DUMP_RD) && !wen_ext_2;

  assign strm.in_ready  = in_rdy;
  assign strm.out_valid = (state == S_DUMP_OUT);
  assign strm.out_data  = out_data_r;
  assign ren_ext        = 1'b0;
  assign ren_ext_2      = rd_go;
  assign addr_ext_2     = rd_go ? {{(ADDR_W-CNT_W-3){1'b0}}, dump_idx, 3'b000} : waddr2;

  loader_counter #(.W(CNT_W)) u_beat (
    .clk(clk), .arst(arst), .clr(state != state_nx), .inc(accept),
    .last(beat_last), .count(beat), .tc(beat_tc));

  loader_counter #(.W(RUN_W)) u_cycle (
    .clk(clk), .arst(arst), .clr(state != S_RUN), .inc(state == S_RUN),
    .last(len.run), .count(cyc), .tc(cyc_tc));

  loader_counter #(.W(CNT_W)) u_dump (
    .clk(clk), .arst(arst), .clr(state == S_IDLE),
    .inc(state == S_DUMP_OUT && strm.out_ready && !dump_tc),
    .last(dump_last), .count(dump_idx), .tc(dump_tc));

  // Sequence FSM next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (start) state_nx = S_LOAD_I;
      S_LOAD_I:    if (len.inst == '0 || (accept && beat_tc)) state_nx = after_phase(S_LOAD_I, len);
      S_LOAD_D:    if (accept && beat_tc) state_nx = after_phase(S_LOAD_D, len);
      S_RUN:       if (cyc_tc) state_nx = after_phase(S_RUN, len);
      S_DUMP_RD:   if (rd_go) state_nx = S_DUMP_WAIT;
      S_DUMP_WAIT: state_nx = S_DUMP_OUT;
      S_DUMP_OUT:  if (strm.out_ready) state_nx = dump_tc ? S_IDLE : S_DUMP_RD;
      default:     state_nx = S_IDLE;
    endcase
  end

  // State, latched lengths and CPU control; cpu_enable lags RUN entry by one
  // cycle so it never overlaps the final memory write of a load phase.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= S_IDLE;
      len        <= '0;
      done       <= 1'b0;
      cpu_enable <= 1'b0;
      cpu_arst_n <= 1'b0;
    end else begin
      state      <= state_nx;
      done       <= busy && (state_nx == S_IDLE);
      cpu_enable <= (state == S_RUN) && !cyc_tc;
      if (state == S_IDLE && start) begin
        len.inst   <= clamp_len(CNT_W'(n_inst), IMEM_DEPTH);
        len.data   <= clamp_len(n_data, DMEM_DEPTH);
        len.dump   <= clamp_len(n_dump, DMEM_DEPTH);
        len.run    <= run_cycles;
        cpu_arst_n <= 1'b0;
      end else if ((state == S_LOAD_I || state == S_LOAD_D) &&
                   state_nx != S_LOAD_I && state_nx != S_LOAD_D) begin
        cpu_arst_n <= 1'b1;
      end
    end
  end

  // Memory write ports trail the accepted beat by one cycle; dump data is
  // captured one cycle after the read strobe.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wen_ext     <= 1'b0;
      addr_ext    <= '0;
      wdata_ext   <= '0;
      wen_ext_2   <= 1'b0;
      waddr2      <= '0;
      wdata_ext_2 <= '0;
      out_data_r  <= '0;
    end else begin
      wen_ext   <= accept && (state == S_LOAD_I);
      wen_ext_2 <= accept && (state == S_LOAD_D);
      if (accept && state == S_LOAD_I) begin
        addr_ext  <= {{(ADDR_W-CNT_W-2){1'b0}}, beat, 2'b00};
        wdata_ext <= strm.in_data[INST_W-1:0];
      end
      if (accept && state == S_LOAD_D) begin
        waddr2      <= {{(ADDR_W-CNT_W-3){1'b0}}, beat, 3'b000};
        wdata_ext_2 <= strm.in_data;
      end
      if (state == S_DUMP_WAIT) out_data_r <= rdata_ext_2;
    end
  end
endmodule

// File: tb/tb_cpu_loader.sv
// Self-checking bench for cpu_loader: random stream data, queue-based expectations.
module tb_cpu_loader;
  logic        clk = 1'b0;
  logic        arst, start;
  logic [9:0]  n_inst;
  logic [10:0] n_data, n_dump;
  logic [31:0] run_cycles;
  logic        busy, done, cpu_enable, cpu_arst_n;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;

  cpu_loader_if bus();

  cpu_loader dut (
    .clk(clk), .arst(arst), .start(start), .n_inst(n_inst), .n_data(n_data),
    .n_dump(n_dump), .run_cycles(run_cycles), .strm(bus.slave), .busy(busy),
    .done(done), .cpu_enable(cpu_enable), .cpu_arst_n(cpu_arst_n),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [63:0] stream[$];
  logic [63:0] dmem[1024];
  logic [63:0] im_addr_q[$], dm_addr_q[$], dm_data_q[$], rd_addr_q[$], out_q[$];
  logic [31:0] im_data_q[$];
  int en_cycles, done_cnt, busy_cycles, overlap, rstn_bad, unstable;
  logic got_done, aborted;
  logic [3:0] snap;

  function automatic logic [63:0] init_word(input int i);
    return {32'(i) ^ 32'hC0DE_0000, 32'hFACE_0000 + 32'(i)};
  endfunction

  function automatic int clampi(input int v, input int d);
    return (v > d) ? d : v;
  endfunction

  // Drives one full sequence and records every observable event.
  task automatic run_seq(input int ni, nd, rc, nr, vmode, rmode, inj, abort_run);
    int idx, stall_left, post;
    logic hs, rd_pend, prev_stall, injected, inj_now;
    logic [63:0] rd_a, held;
    im_addr_q.delete(); im_data_q.delete(); dm_addr_q.delete(); dm_data_q.delete();
    rd_addr_q.delete(); out_q.delete(); stream.delete();
    en_cycles = 0; done_cnt = 0; busy_cycles = 0; overlap = 0; rstn_bad = 0; unstable = 0;
    got_done = 0; aborted = 0; snap = '0;
    for (int i = 0; i < ni + nd + 16; i++) stream.push_back({$urandom, $urandom});
    for (int i = 0; i < 1024; i++) dmem[i] = init_word(i);
    idx = 0; stall_left = (rmode == 2) ? 3 : 0; post = 0;
    prev_stall = 0; held = '0; injected = 0; inj_now = 0; rd_pend = 0; rd_a = '0;
    n_inst = 10'(ni); n_data = 11'(nd); n_run_set(rc); n_dump = 11'(nr);
    bus.in_valid = 1'b1; bus.in_data = stream[0];
    bus.out_ready = (rmode != 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_inst = 10'($urandom); n_data = 11'($urandom); n_dump = 11'($urandom); run_cycles = $urandom;
    for (int cyc = 0; cyc < 30000 && post < 3; cyc++) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      if (wen_ext) begin im_addr_q.push_back(addr_ext); im_data_q.push_back(wdata_ext); end
      if (wen_ext_2) begin
        dm_addr_q.push_back(addr_ext_2); dm_data_q.push_back(wdata_ext_2);
        if (addr_ext_2[2:0] == 3'b0 && addr_ext_2 < 64'd8192) dmem[addr_ext_2[12:3]] = wdata_ext_2;
        if (inj && !injected) begin injected = 1; inj_now = 1; end
      end
      rd_pend = ren_ext_2; rd_a = addr_ext_2;
      if (ren_ext_2) rd_addr_q.push_back(addr_ext_2);
      if (ren_ext) overlap++;
      if (cpu_enable) en_cycles++;
      if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) overlap++;
      if (wen_ext_2 && ren_ext_2) overlap++;
      if ((bus.in_ready && cpu_arst_n) || (cpu_enable && !cpu_arst_n)) rstn_bad++;
      if (busy) busy_cycles++;
      if (done) begin done_cnt++; got_done = 1; end
      if (prev_stall && bus.out_valid && bus.out_data !== held) unstable++;
      prev_stall = bus.out_valid && !bus.out_ready; held = bus.out_data;
      if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_data);
      if (bus.out_valid && stall_left > 0) stall_left--;
      if (got_done) post++;
      if (abort_run && cpu_enable) begin
        #2 arst = 1'b1;
        #1 snap = {cpu_enable, cpu_arst_n, busy, done};
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      if (hs) idx++;
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = !bus.in_valid;
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = (idx < stream.size()) ? stream[idx] : 64'd0;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (stall_left == 0);
      endcase
      rdata_ext_2 = (rd_pend && rd_a[2:0] == 3'b0 && rd_a < 64'd8192) ? dmem[rd_a[12:3]]
                                                                     : {$urandom, $urandom};
      if (inj_now) begin
        start = 1'b1; inj_now = 0;
        n_inst = 10'($urandom_range(1, 9)); n_data = 11'($urandom_range(1, 9));
        n_dump = 11'($urandom_range(1, 9)); run_cycles = $urandom_range(1, 9);
      end else start = 1'b0;
    end
    start = 1'b0; bus.in_valid = 1'b0;
  endtask

  task automatic n_run_set(input int rc);
    run_cycles = 32'(rc);
  endtask

  task automatic test_reset();
    arst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rdata_ext_2 = '0; n_inst = '0; n_data = '0; n_dump = '0; run_cycles = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, bus.in_ready, bus.out_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2} !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000000",
        {busy, done, bus.in_ready, bus.out_valid, cpu_enable, wen_ext, ren_ext, wen_ext_2, ren_ext_2});
    end
    n_tests++;
    if (cpu_arst_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_arst_n: got %b want 0", cpu_arst_n); end
    n_tests++;
    if ({addr_ext, addr_ext_2, wdata_ext, wdata_ext_2, bus.out_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", addr_ext, addr_ext_2);
    end
    arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_load_run_dump();
    int ni, nd, rc, nr, vm, rm, eni, end_, enr, bad;
    logic [63:0] a, e;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: begin ni = 3; nd = 2; rc = 5; nr = 2; vm = 0; rm = 0; end
        1: begin ni = 700; nd = 1500; rc = 3; nr = 1100; vm = 2; rm = 1; end
        default: begin
          ni = $urandom_range(0, 12); nd = $urandom_range(0, 12);
          rc = $urandom_range(0, 8); nr = $urandom_range(0, 14); vm = 2; rm = 1;
        end
      endcase
      run_seq(ni, nd, rc, nr, vm, rm, 0, 0);
      eni = clampi(ni, 512); end_ = clampi(nd, 1024); enr = clampi(nr, 1024);
      n_tests++;
      if (!got_done || done_cnt != 1) begin n_fail++; $display("FAIL lrd%0d_done: got %0d pulses want 1", s, done_cnt); end
      bad = 0; a = '0; e = '0;
      if (im_addr_q.size() != eni) begin bad = 1; a = 64'(im_addr_q.size()); e = 64'(eni); end
      for (int k = 0; k < eni && !bad; k++)
        if (im_addr_q[k] !== 64'(4 * k)) begin bad = 1; a = im_addr_q[k]; e = 64'(4 * k); end
        else if (im_data_q[k] !== stream[k][31:0]) begin bad = 1; a = 64'(im_data_q[k]); e = 64'(stream[k][31:0]); end
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL lrd%0d_imem: got %h want %h", s, a, e); end
      bad = 0;
      if (dm_addr_q.size() != end_) begin bad = 1; a = 64'(dm_addr_q.size()); e = 64'(end_); end
      for (int k = 0; k < end_ && !bad; k++)
        if (dm_addr_q[k] !== 64'(8 * k)) begin bad = 1; a = dm_addr_q[k]; e = 64'(8 * k); end
        else if (dm_data_q[k] !== stream[eni + k]) begin bad = 1; a = dm_data_q[k]; e = stream[eni + k]; end
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL lrd%0d_dmem: got %h want %h", s, a, e); end
      bad = 0;
      if (rd_addr_q.size() != enr || out_q.size() != enr) begin
        bad = 1; a = 64'(rd_addr_q.size()); e = 64'(enr);
      end
      for (int j = 0; j < enr && !bad; j++)
        if (rd_addr_q[j] !== 64'(8 * j)) begin bad = 1; a = rd_addr_q[j]; e = 64'(8 * j); end
        else if (out_q[j] !== ((j < end_) ? stream[eni + j] : init_word(j))) begin
          bad = 1; a = out_q[j]; e = (j < end_) ? stream[eni + j] : init_word(j);
        end
      n_tests++;
      if (bad) begin n_fail++; $display("FAIL lrd%0d_dump: got %h want %h", s, a, e); end
      n_tests++;
      if (en_cycles != rc) begin n_fail++; $display("FAIL lrd%0d_enable: got %0d cycles want %0d", s, en_cycles, rc); end
      n_tests++;
      if (overlap != 0 || rstn_bad != 0) begin
        n_fail++; $display("FAIL lrd%0d_strobes: got overlap=%0d rstn_bad=%0d want 0 0", s, overlap, rstn_bad);
      end
      n_tests++;
      if (cpu_arst_n !== 1'b1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL lrd%0d_end: got cpu_arst_n=%b busy=%b want 1 0", s, cpu_arst_n, busy);
      end
    end
  endtask

  task automatic test_valid_toggle();
    int bad;
    run_seq(4, 0, 0, 0, 1, 0, 0, 0);
    n_tests++;
    if (im_addr_q.size() != 4) begin n_fail++; $display("FAIL toggle_count: got %0d writes want 4", im_addr_q.size()); end
    bad = -1;
    for (int k = 0; k < 4 && k < im_addr_q.size(); k++)
      if (bad < 0 && (im_addr_q[k] !== 64'(4 * k) || im_data_q[k] !== stream[k][31:0])) bad = k;
    n_tests++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL toggle_write%0d: got addr %h data %h want addr %h data %h",
        bad, im_addr_q[bad], im_data_q[bad], 64'(4 * bad), stream[bad][31:0]);
    end
    n_tests++;
    if (done_cnt != 1 || dm_addr_q.size() != 0) begin
      n_fail++; $display("FAIL toggle_done: got done=%0d dwrites=%0d want 1 0", done_cnt, dm_addr_q.size());
    end
  endtask

  task automatic test_out_stall();
    run_seq(0, 2, 0, 2, 0, 2, 0, 0);
    n_tests++;
    if (unstable != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
    n_tests++;
    if (rd_addr_q.size() != 2) begin n_fail++; $display("FAIL stall_reads: got %0d want 2", rd_addr_q.size()); end
    n_tests++;
    if (out_q.size() != 2 || out_q[0] !== stream[0] || out_q[1] !== stream[1]) begin
      n_fail++; $display("FAIL stall_data: got %0d beats first %h want 2 beats first %h",
        out_q.size(), (out_q.size() > 0) ? out_q[0] : 64'd0, stream[0]);
    end
    n_tests++;
    if (overlap != 0 || done_cnt != 1) begin
      n_fail++; $display("FAIL stall_misc: got overlap=%0d done=%0d want 0 1", overlap, done_cnt);
    end
  endtask

  task automatic test_zero_lengths();
    int strobes;
    run_seq(0, 0, 0, 0, 0, 0, 0, 0);
    strobes = im_addr_q.size() + dm_addr_q.size() + rd_addr_q.size() + en_cycles + out_q.size() + overlap;
    n_tests++;
    if (busy_cycles != 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles want 1", busy_cycles); end
    n_tests++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL zero_done: got %0d want 1", done_cnt); end
    n_tests++;
    if (strobes != 0) begin n_fail++; $display("FAIL zero_strobes: got %0d want 0", strobes); end
  endtask

  task automatic test_start_ignored();
    run_seq(2, 4, 2, 1, 0, 0, 1, 0);
    n_tests++;
    if (im_addr_q.size() != 2 || dm_addr_q.size() != 4) begin
      n_fail++; $display("FAIL ign_loads: got %0d/%0d want 2/4", im_addr_q.size(), dm_addr_q.size());
    end
    n_tests++;
    if (en_cycles != 2 || rd_addr_q.size() != 1) begin
      n_fail++; $display("FAIL ign_run_dump: got en=%0d reads=%0d want 2 1", en_cycles, rd_addr_q.size());
    end
    n_tests++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ign_end: got done=%0d busy=%b want 1 0", done_cnt, busy);
    end
  endtask

  task automatic test_reset_in_run();
    int late_done;
    run_seq(1, 1, 20, 1, 0, 0, 0, 1);
    n_tests++;
    if (!aborted) begin n_fail++; $display("FAIL rr_reach_run: got no cpu_enable want enable within budget"); end
    n_tests++;
    if (snap !== 4'b0000) begin n_fail++; $display("FAIL rr_drop: got en/rstn/busy/done=%b want 0000", snap); end
    late_done = 0;
    @(posedge clk); #1 arst = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (done) late_done++; end
    @(posedge clk); #1;
    n_tests++;
    if (late_done != 0 || done_cnt != 0) begin
      n_fail++; $display("FAIL rr_no_done: got %0d pulses want 0", late_done + done_cnt);
    end
    run_seq(2, 1, 3, 1, 0, 0, 0, 0);
    n_tests++;
    if (done_cnt != 1 || en_cycles != 3 || im_addr_q.size() != 2) begin
      n_fail++; $display("FAIL rr_restart: got done=%0d en=%0d iw=%0d want 1 3 2", done_cnt, en_cycles, im_addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_load_run_dump();
    test_valid_toggle();
    test_out_stall();
    test_zero_lengths();
    test_start_ignored();
    test_reset_in_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
